// File: rtl/bespoke_stream_pkg.sv
// Shared types and helpers for the bespoke_io_core stream adapter.
package bespoke_stream_pkg;

  localparam int BYTE_W = 8;
  localparam int IN_DEPTH_DEF = 16;
  localparam int OUT_DEPTH_DEF = 16;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } in_entry_t;

  localparam logic FR_IDLE = 1'b0;
  localparam logic FR_IN = 1'b1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bespoke_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module bespoke_sync_fifo
  import bespoke_stream_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (wp == rp);
  assign full = (wp[AW] != rp[AW]) &&
                (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bespoke_stream_adapter.sv
// Converts bespoke_io_core toggle probes to/from valid/ready byte streams.
// Optional frame checking: define BESPOKE_STREAM_FRAME_CHECK_EN.
module bespoke_stream_adapter
  import bespoke_stream_pkg::*;
#(
  parameter int IN_DEPTH = IN_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              all_in_ready,
  input  logic              pc_data_put,
  input  logic              pc_data_req,
  output logic [BYTE_W-1:0] byte_out,
  output logic              all_out_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              overflow,
  output logic              underflow
`ifdef BESPOKE_STREAM_FRAME_CHECK_EN
  ,
  output logic [15:0]       frame_count,
  output logic              frame_err
`endif
);

  logic      armed;
  logic      put_ref;
  logic      req_ref;
  logic      put_evt;
  logic      req_evt;
  in_entry_t in_w;
  in_entry_t in_r;
  logic      in_full;
  logic      in_empty;
  logic      in_pop;
  logic      eg_full;
  logic      eg_empty;
  logic      eg_pop;
  logic      eg_push;

  // Levels present at reset release are captured, not treated as toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      put_ref <= 1'b0;
      req_ref <= 1'b0;
    end else begin
      armed <= 1'b1;
      put_ref <= pc_data_put;
      req_ref <= pc_data_req;
    end
  end

  assign put_evt = armed & (pc_data_put ^ put_ref);
  assign req_evt = armed & (pc_data_req ^ req_ref);

  assign in_w = '{last: all_in_ready, data: byte_in};
  assign m_valid = ~in_empty;
  assign m_data = in_r.data;
  assign m_last = in_r.last;
  assign in_pop = m_valid & m_ready;

  bespoke_sync_fifo #(
    .W($bits(in_entry_t)),
    .DEPTH(IN_DEPTH)
  ) u_in_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(put_evt),
    .wdata(in_w),
    .pop(in_pop),
    .rdata(in_r),
    .full(in_full),
    .empty(in_empty)
  );

  assign all_out_ready = ~eg_empty;
  assign eg_pop = req_evt & ~eg_empty;
  assign s_ready = rst_n & (~eg_full | eg_pop);
  assign eg_push = s_valid & s_ready;

  bespoke_sync_fifo #(
    .W(BYTE_W),
    .DEPTH(OUT_DEPTH)
  ) u_eg_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(eg_push),
    .wdata(s_data),
    .pop(eg_pop),
    .rdata(byte_out),
    .full(eg_full),
    .empty(eg_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (put_evt & in_full & ~in_pop) overflow <= 1'b1;
      if (req_evt & eg_empty) underflow <= 1'b1;
    end
  end

`ifdef BESPOKE_STREAM_FRAME_CHECK_EN
  localparam int LW = ptr_w(IN_DEPTH);

  logic          fr_state;
  logic [LW-1:0] last_cnt;
  logic          in_acc;
  logic          last_in;
  logic          last_out;

  assign in_acc = put_evt & (~in_full | in_pop);
  assign last_in = in_acc & all_in_ready;
  assign last_out = in_pop & in_r.last;

  // A full FIFO holding no last flag means the frame outgrew the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr_state <= FR_IDLE;
      last_cnt <= '0;
      frame_count <= '0;
      frame_err <= 1'b0;
    end else begin
      if (put_evt) begin
        unique case (1'b1)
          all_in_ready: fr_state <= FR_IDLE;
          default: fr_state <= FR_IN;
        endcase
      end
      if (put_evt && in_full && fr_state == FR_IN &&
          last_cnt == '0)
        frame_err <= 1'b1;
      if (last_in && !last_out) last_cnt <= last_cnt + 1'b1;
      else if (!last_in && last_out) last_cnt <= last_cnt - 1'b1;
      if (last_out) frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
